// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the R-type control sequencer: the sequencer state
// encoding, the ALU opcode map and small opcode classification helpers.
package cpu_ctrl_pkg;

  // Opcodes are 5 bits wide in the instruction format.
  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_ADD = 5'b00001;
  localparam logic [OPC_W-1:0] OP_SUB = 5'b00010;
  localparam logic [OPC_W-1:0] OP_AND = 5'b00011;
  localparam logic [OPC_W-1:0] OP_OR  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_SHR = 5'b00101;
  localparam logic [OPC_W-1:0] OP_SHL = 5'b00110;
  localparam logic [OPC_W-1:0] OP_ROR = 5'b00111;
  localparam logic [OPC_W-1:0] OP_ROL = 5'b01000;
  localparam logic [OPC_W-1:0] OP_MUL = 5'b01001;
  localparam logic [OPC_W-1:0] OP_DIV = 5'b01010;
  localparam logic [OPC_W-1:0] OP_NEG = 5'b01011;
  localparam logic [OPC_W-1:0] OP_NOT = 5'b01100;

  // One state per control step: fetch (T0-T2), decode (T3), execute (T4-T6).
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_DONE
  } state_t;

  // True for every opcode the datapath ALU implements.
  function automatic logic is_legal_op(input logic [OPC_W-1:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL,
      OP_MUL, OP_DIV, OP_NEG, OP_NOT: legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Two-operand ops read Rc onto the bus in T4; NEG/NOT only use Y (Rb).
  function automatic logic is_two_operand(input logic [OPC_W-1:0] op);
    return is_legal_op(op) && (op != OP_NEG) && (op != OP_NOT);
  endfunction

  // MUL/DIV produce a 64-bit result that lands in the HI/LO pair.
  function automatic logic is_muldiv(input logic [OPC_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/ir_field_decode.sv
// Splits an instruction word into opcode and Ra/Rb/Rc, turns each register
// field into a one-hot select and flags instructions the sequencer cannot run.
module ir_field_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = $clog2(NUM_REGS),
  parameter int OPCODE_W  = 5,
  parameter int IR_W      = 32
) (
  input  logic [IR_W-1:0]     ir,
  output logic [OPCODE_W-1:0] opcode,
  output logic [NUM_REGS-1:0] ra_sel,
  output logic [NUM_REGS-1:0] rb_sel,
  output logic [NUM_REGS-1:0] rc_sel,
  output logic                two_operand,
  output logic                muldiv,
  output logic                illegal
);

  // Field positions, MSB-first after the opcode.
  localparam int RA_MSB = IR_W - 1 - OPCODE_W;
  localparam int RB_MSB = RA_MSB - REG_IDX_W;
  localparam int RC_MSB = RB_MSB - REG_IDX_W;
  localparam int LOW_W  = RC_MSB + 1 - REG_IDX_W;

  logic [REG_IDX_W-1:0] ra;
  logic [REG_IDX_W-1:0] rb;
  logic [REG_IDX_W-1:0] rc;
  logic                 op_legal;

  assign opcode = ir[IR_W-1 -: OPCODE_W];
  assign ra     = ir[RA_MSB -: REG_IDX_W];
  assign rb     = ir[RB_MSB -: REG_IDX_W];
  assign rc     = ir[RC_MSB -: REG_IDX_W];

  // A field that names a register beyond NUM_REGS matches no select bit,
  // so its one-hot vector is all zero and that doubles as the range check.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_sel
      assign ra_sel[gi] = (ra == REG_IDX_W'(gi));
      assign rb_sel[gi] = (rb == REG_IDX_W'(gi));
      assign rc_sel[gi] = (rc == REG_IDX_W'(gi));
    end
  endgenerate

  // Immediate / spare bits below Rc are not used by R-type instructions.
  generate
    if (LOW_W > 0) begin : g_low
      logic unused_low;
      assign unused_low = ^ir[LOW_W-1:0];
    end
  endgenerate

  assign op_legal    = is_legal_op(OPC_W'(opcode));
  assign two_operand = is_two_operand(OPC_W'(opcode));
  assign muldiv      = is_muldiv(OPC_W'(opcode));
  assign illegal     = !op_legal || !(|ra_sel) || !(|rb_sel) || !(|rc_sel);

endmodule

// File: rtl/rtype_control_sequencer.sv
// Control-step sequencer for the single-bus datapath: fetches one instruction
// and executes a register-register ALU op, one control step per state.
// Optional build macro SEQ_STEP_EN: when defined every non-IDLE state holds
// (strobes still asserted) until `step` is high at a clock edge.
module rtype_control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = $clog2(NUM_REGS),
  parameter int OPCODE_W  = 5,
  parameter int IR_W      = 32
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic                step,
  input  logic [IR_W-1:0]     ir,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic                pc_out,
  output logic                inc_pc,
  output logic                mar_in,
  output logic                pc_in,
  output logic                read,
  output logic                mdr_in,
  output logic                mdr_out,
  output logic                ir_in,
  output logic                y_in,
  output logic                z_in,
  output logic                z_low_out,
  output logic                z_high_out,
  output logic                hi_in,
  output logic                lo_in,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [OPCODE_W-1:0] alu_op
);

  state_t state;
  state_t state_next;

  // Copy of the instruction taken in T3 so the datapath IR may change later.
  logic [IR_W-1:0] ir_held;
  logic            illegal_held;

  logic [IR_W-1:0]     ir_dec;
  logic [OPCODE_W-1:0] dec_opcode;
  logic [NUM_REGS-1:0] dec_ra_sel;
  logic [NUM_REGS-1:0] dec_rb_sel;
  logic [NUM_REGS-1:0] dec_rc_sel;
  logic                dec_two_operand;
  logic                dec_muldiv;
  logic                dec_illegal;
  logic                advance;

`ifdef SEQ_STEP_EN
  assign advance = step;
`else
  logic unused_step;
  assign advance     = 1'b1;
  assign unused_step = step;
`endif

  // T3 decodes the live IR (it is being captured that cycle); later steps
  // work from the held copy.
  assign ir_dec = (state == ST_T3) ? ir : ir_held;

  ir_field_decode #(
    .NUM_REGS  (NUM_REGS),
    .REG_IDX_W (REG_IDX_W),
    .OPCODE_W  (OPCODE_W),
    .IR_W      (IR_W)
  ) u_decode (
    .ir          (ir_dec),
    .opcode      (dec_opcode),
    .ra_sel      (dec_ra_sel),
    .rb_sel      (dec_rb_sel),
    .rc_sel      (dec_rc_sel),
    .two_operand (dec_two_operand),
    .muldiv      (dec_muldiv),
    .illegal     (dec_illegal)
  );

  // State register; clr drops straight back to IDLE from any step.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the instruction and its legality in T3; forget it once idle.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ir_held      <= '0;
      illegal_held <= 1'b0;
    end else if (state == ST_T3) begin
      ir_held      <= ir;
      illegal_held <= dec_illegal;
    end else if (state == ST_IDLE) begin
      ir_held      <= '0;
      illegal_held <= 1'b0;
    end
  end

  // Next-state and strobe decode from the registered state.
  always_comb begin
    state_next = state;
    busy       = (state != ST_IDLE);
    done       = 1'b0;
    illegal    = 1'b0;
    pc_out     = 1'b0;
    inc_pc     = 1'b0;
    mar_in     = 1'b0;
    pc_in      = 1'b0;
    read       = 1'b0;
    mdr_in     = 1'b0;
    mdr_out    = 1'b0;
    ir_in      = 1'b0;
    y_in       = 1'b0;
    z_in       = 1'b0;
    z_low_out  = 1'b0;
    z_high_out = 1'b0;
    hi_in      = 1'b0;
    lo_in      = 1'b0;
    reg_in     = '0;
    reg_out    = '0;
    alu_op     = '0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_T0;
        end
      end

      // MAR <- PC, Z <- PC + 1
      ST_T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
        if (advance) begin
          state_next = ST_T1;
        end
      end

      // PC <- Z, MDR <- M[MAR]
      ST_T1: begin
        z_low_out = 1'b1;
        pc_in     = 1'b1;
        read      = 1'b1;
        mdr_in    = 1'b1;
        if (advance) begin
          state_next = ST_T2;
        end
      end

      // IR <- MDR
      ST_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
        if (advance) begin
          state_next = ST_T3;
        end
      end

      // Y <- Rb, or bail out to DONE without touching the datapath
      ST_T3: begin
        if (!dec_illegal) begin
          reg_out = dec_rb_sel;
          y_in    = 1'b1;
        end
        if (advance) begin
          state_next = dec_illegal ? ST_DONE : ST_T4;
        end
      end

      // Z <- Y op Rc (or op Y for NEG/NOT)
      ST_T4: begin
        alu_op = dec_opcode;
        z_in   = 1'b1;
        if (dec_two_operand) begin
          reg_out = dec_rc_sel;
        end
        if (advance) begin
          state_next = ST_T5;
        end
      end

      // Ra <- Zlow, or LO <- Zlow for mul/div
      ST_T5: begin
        z_low_out = 1'b1;
        if (dec_muldiv) begin
          lo_in = 1'b1;
        end else begin
          reg_in = dec_ra_sel;
        end
        if (advance) begin
          state_next = dec_muldiv ? ST_T6 : ST_DONE;
        end
      end

      // HI <- Zhigh
      ST_T6: begin
        z_high_out = 1'b1;
        hi_in      = 1'b1;
        if (advance) begin
          state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        illegal = illegal_held;
        if (advance) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rtype_control_sequencer.sv
// Self-checking bench for rtype_control_sequencer: directed and random
// instructions compared cycle by cycle against a table-driven model.
module tb_rtype_control_sequencer;

  localparam int NR   = 16;
  localparam int NR_S = 8;
`ifdef SEQ_STEP_EN
  localparam int HOLD = 3;
`else
  localparam int HOLD = 1;
`endif

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        start_s;
  logic        step;
  logic [31:0] ir;
  logic [31:0] ir_s;

  logic busy, done, illegal, pc_out, inc_pc, mar_in, pc_in, read, mdr_in;
  logic mdr_out, ir_in, y_in, z_in, z_low_out, z_high_out, hi_in, lo_in;
  logic [NR-1:0] reg_in, reg_out;
  logic [4:0]    alu_op;

  logic busy_s, done_s, illegal_s, pc_out_s, inc_pc_s, mar_in_s, pc_in_s;
  logic read_s, mdr_in_s, mdr_out_s, ir_in_s, y_in_s, z_in_s, z_low_out_s;
  logic z_high_out_s, hi_in_s, lo_in_s;
  logic [NR_S-1:0] reg_in_s, reg_out_s;
  logic [4:0]      alu_op_s;

  typedef struct packed {
    logic busy, done, illegal, pc_out, inc_pc, mar_in, pc_in, read, mdr_in;
    logic mdr_out, ir_in, y_in, z_in, z_low_out, z_high_out, hi_in, lo_in;
    logic [NR-1:0] reg_in;
    logic [NR-1:0] reg_out;
    logic [4:0]    alu_op;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  rtype_control_sequencer #(.NUM_REGS(NR)) u_dut (
    .clk(clk), .clr(clr), .start(start), .step(step), .ir(ir),
    .busy(busy), .done(done), .illegal(illegal),
    .pc_out(pc_out), .inc_pc(inc_pc), .mar_in(mar_in), .pc_in(pc_in),
    .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
    .y_in(y_in), .z_in(z_in), .z_low_out(z_low_out), .z_high_out(z_high_out),
    .hi_in(hi_in), .lo_in(lo_in), .reg_in(reg_in), .reg_out(reg_out),
    .alu_op(alu_op)
  );

  // Eight registers but 4-bit fields, so out-of-range indices are encodable.
  rtype_control_sequencer #(.NUM_REGS(NR_S), .REG_IDX_W(4)) u_small (
    .clk(clk), .clr(clr), .start(start_s), .step(step), .ir(ir_s),
    .busy(busy_s), .done(done_s), .illegal(illegal_s),
    .pc_out(pc_out_s), .inc_pc(inc_pc_s), .mar_in(mar_in_s), .pc_in(pc_in_s),
    .read(read_s), .mdr_in(mdr_in_s), .mdr_out(mdr_out_s), .ir_in(ir_in_s),
    .y_in(y_in_s), .z_in(z_in_s), .z_low_out(z_low_out_s),
    .z_high_out(z_high_out_s), .hi_in(hi_in_s), .lo_in(lo_in_s),
    .reg_in(reg_in_s), .reg_out(reg_out_s), .alu_op(alu_op_s)
  );

  function automatic obs_t sample();
    obs_t o;
    o = {busy, done, illegal, pc_out, inc_pc, mar_in, pc_in, read, mdr_in,
         mdr_out, ir_in, y_in, z_in, z_low_out, z_high_out, hi_in, lo_in,
         reg_in, reg_out, alu_op};
    return o;
  endfunction

  function automatic logic [31:0] mk(input int opc, input int ra, input int rb, input int rc);
    return {5'(opc), 4'(ra), 4'(rb), 4'(rc), 15'(0)};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, expv);
    end
  endtask

  // Reference: the sequence of control steps an instruction should produce,
  // derived from its opcode class and register fields.
  task automatic build_trace(input logic [31:0] irv);
    logic [4:0] opc;
    int   ra, rb, rc;
    bit   legal, two, md;
    obs_t o;
    opc   = irv[31:27];
    ra    = int'(irv[26:23]);
    rb    = int'(irv[22:19]);
    rc    = int'(irv[18:15]);
    legal = (opc >= 5'd1) && (opc <= 5'd12) && (ra < NR) && (rb < NR) && (rc < NR);
    two   = (opc <= 5'd10);
    md    = (opc == 5'd9) || (opc == 5'd10);
    exp_q.delete();
    o = '0; o.busy = 1; o.pc_out = 1; o.mar_in = 1; o.inc_pc = 1; o.z_in = 1;
    exp_q.push_back(o);
    o = '0; o.busy = 1; o.z_low_out = 1; o.pc_in = 1; o.read = 1; o.mdr_in = 1;
    exp_q.push_back(o);
    o = '0; o.busy = 1; o.mdr_out = 1; o.ir_in = 1;
    exp_q.push_back(o);
    o = '0; o.busy = 1;
    if (legal) begin
      o.reg_out = 16'(1) << rb;
      o.y_in    = 1;
    end
    exp_q.push_back(o);
    if (legal) begin
      o = '0; o.busy = 1; o.alu_op = opc; o.z_in = 1;
      if (two) o.reg_out = 16'(1) << rc;
      exp_q.push_back(o);
      o = '0; o.busy = 1; o.z_low_out = 1;
      if (md) o.lo_in = 1;
      else    o.reg_in = 16'(1) << ra;
      exp_q.push_back(o);
      if (md) begin
        o = '0; o.busy = 1; o.z_high_out = 1; o.hi_in = 1;
        exp_q.push_back(o);
      end
    end
    o = '0; o.busy = 1; o.done = 1; o.illegal = !legal;
    exp_q.push_back(o);
  endtask

  // mode 0: plain; 1: extra start pulse while busy; 2: start held -> relaunch.
  // Entered and left on a falling edge.
  task automatic run_instr(input string tag, input logic [31:0] irv, input int mode);
    int passes;
    passes = (mode == 2) ? 2 : 1;
    build_trace(irv);
    start = 1'b1;
    for (int p = 0; p < passes; p++) begin
      ir = irv;
      for (int i = 0; i < exp_q.size(); i++) begin
        for (int k = 0; k < HOLD; k++) begin
          @(posedge clk);
          @(negedge clk);
          check($sformatf("%s p%0d c%0d k%0d", tag, p, i, k), 64'(sample()), 64'(exp_q[i]));
          step = (HOLD == 1) ? 1'($urandom) : ((k == HOLD - 1) ? 1'b1 : 1'b0);
        end
        if (i == 0 && (mode != 2 || p == 1)) start = 1'b0;
        if (mode == 1 && i == 1) start = 1'b1;
        if (mode == 1 && i == 2) start = 1'b0;
        if (i >= 4) ir = $urandom;
      end
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s p%0d idle", tag, p), 64'(sample()), 64'(0));
    end
    @(posedge clk);
    @(negedge clk);
    check($sformatf("%s no_relaunch", tag), 64'(sample()), 64'(0));
  endtask

  task automatic run_small(input string tag, input logic [31:0] irv, input int exp_lat,
                           input logic exp_ill, input logic [7:0] exp_in, input logic [7:0] exp_out);
    int         lat;
    logic [7:0] seen_in, seen_out;
    logic       got_ill;
    ir_s     = irv;
    start_s  = 1'b1;
    step     = 1'b1;
    seen_in  = '0;
    seen_out = '0;
    @(posedge clk);
    @(negedge clk);
    start_s = 1'b0;
    lat     = 1;
    while (!done_s && lat < 20) begin
      seen_in  = seen_in | reg_in_s;
      seen_out = seen_out | reg_out_s;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    got_ill = illegal_s;
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " illegal"}, 64'(got_ill), 64'(exp_ill));
    check({tag, " reg_in"}, 64'(seen_in), 64'(exp_in));
    check({tag, " reg_out"}, 64'(seen_out), 64'(exp_out));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] irv;
    logic [4:0]  opc;

    clr = 1'b0; start = 1'b0; start_s = 1'b0; step = 1'b0; ir = '0; ir_s = '0;
    #1;
    check("reset outputs", 64'(sample()), 64'(0));
    check("reset small done/illegal", 64'({done_s, illegal_s, busy_s}), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("idle after reset", 64'(sample()), 64'(0));

    run_instr("sub_r0_r4_r5", mk(2, 0, 4, 5), 0);
    run_instr("mul_r2_r3", mk(9, 1, 2, 3), 0);
    run_instr("not_r1_r6", mk(12, 1, 6, 0), 0);
    run_instr("illegal_op", mk(31, 1, 2, 3), 0);
    run_instr("op_zero", mk(0, 3, 3, 3), 0);
    run_instr("div_busy_start", mk(10, 7, 8, 9), 1);
    run_instr("add_relaunch", mk(1, 15, 14, 13), 2);

    // Reset in the middle of T4.
    build_trace(mk(2, 0, 4, 5));
    ir = mk(2, 0, 4, 5);
    step = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre-reset T4", 64'(sample()), 64'(exp_q[4]));
    #2 clr = 1'b0;
    #1;
    check("async reset", 64'(sample()), 64'(0));
    @(posedge clk);
    @(negedge clk);
    check("reset held", 64'(sample()), 64'(0));
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("idle after mid reset", 64'(sample()), 64'(0));
    run_instr("after_reset", mk(3, 5, 6, 7), 0);

    run_small("small rc9", mk(1, 0, 1, 9), 5, 1'b1, 8'h00, 8'h00);
    run_small("small add", mk(1, 7, 1, 2), 7, 1'b0, 8'h80, 8'h06);

    for (int n = 0; n < 30; n++) begin
      opc = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(1, 12));
      irv = {opc, 27'($urandom)};
      run_instr($sformatf("rnd%0d op%0d", n, opc), irv, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rtype_control_sequencer.md
# rtype_control_sequencer

Control-step sequencer that drives the existing single-bus datapath through instruction fetch and execution of register-register ALU instructions. It replaces hand-sequenced T0–T6 control signals with a parametrised finite state machine. It supports an arbitrary register-file size, two-operand and one-operand ALU ops, and mul/div writes to the HI/LO pair. It sits between the future top-level control unit (which raises `start`) and the datapath control inputs.

## Interface
- `NUM_REGS`, 16, general registers; one-hot `reg_in`/`reg_out` width
- `REG_IDX_W`, `$clog2(NUM_REGS)`, register-field width in the IR
- `OPCODE_W`, 5, ALU opcode width
- `IR_W`, 32, instruction width; opcode `ir[IR_W-1 -: OPCODE_W]`, Ra/Rb/Rc fields follow MSB-first, `REG_IDX_W` each
- `clk  in  1  system clock; all state changes on rising edge`
- `clr  in  1  reset; asynchronous, active-low`
- `start  in  1  begin one instruction; sampled only in IDLE`
- `step  in  1  advance enable (used only with SEQ_STEP_EN)`
- `ir  in  IR_W  datapath IR contents`
- `busy  out  1  high in every state except IDLE`
- `done  out  1  one-cycle pulse in DONE`
- `illegal  out  1  valid with done; opcode or register index unsupported`
- `pc_out, inc_pc, mar_in, pc_in, read, mdr_in, mdr_out, ir_in, y_in, z_in, z_low_out, z_high_out, hi_in, lo_in  out  1 each  datapath strobes`
- `reg_in, reg_out  out  NUM_REGS  one-hot register strobes`
- `alu_op  out  OPCODE_W  ALU opcode; zero except in T4`

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, DONE.
- IDLE: all strobes 0. `start`=1 moves to T0.
- T0: `pc_out`, `mar_in`, `inc_pc`, `z_in`.
- T1: `z_low_out`, `pc_in`, `read`, `mdr_in`.
- T2: `mdr_out`, `ir_in`.
- T3: `ir` decoded and captured into an internal copy, held until IDLE.
  - Legal op: `reg_out[Rb]`, `y_in`.
  - Illegal op: no strobes; next state DONE with `illegal`=1.
- T4: `alu_op`=opcode and `z_in`. `reg_out[Rc]` is also asserted for two-operand ops only; NEG/NOT assert no `reg_out`.
- T5: `z_low_out`. Mul/div assert `lo_in`, then go to T6. All other ops assert `reg_in[Ra]`, then go to DONE.
- T6 (mul/div only): `z_high_out`, `hi_in`.
- DONE: `done`=1, then IDLE.
- Opcodes: ADD 00001, SUB 00010, AND 00011, OR 00100, SHR 00101, SHL 00110, ROR 00111, ROL 01000, MUL 01001, DIV 01010, NEG 01011, NOT 01100.
- Illegal conditions:
  - Any opcode not listed above.
  - Any register field ≥ `NUM_REGS`.
- At most one bit of `reg_in`/`reg_out` is high in any cycle. R0 is writable.

## Timing
- Each T-state lasts exactly one cycle (no SEQ_STEP_EN). Strobes are decoded from the registered state and are glitch-free within the cycle.
- Latency from the `start` edge to `done`:
  - Ordinary op: 7 cycles (T0–T5, DONE).
  - Mul/div: 8 cycles.
  - Illegal op: 5 cycles.
- `start` while `busy` is ignored. `start` held high re-launches from IDLE on the cycle after DONE.
- Reset: `clr` low forces IDLE immediately, mid-instruction included. All outputs, including `done` and `illegal`, are 0 while reset is asserted and after release.

## Configuration
- `SEQ_STEP_EN` defined:
  - Every state except IDLE holds, with its strobes still asserted, until `step`=1 at a clock edge.
  - DONE also waits for `step`; `done` stays high during the wait.
- Undefined: `step` is ignored.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - State enum.
  - Opcode localparams.
  - Function `is_legal_op`.
  - Function `is_two_operand`.
  - Function `is_muldiv`.
- One sub-module, `ir_field_decode`: splits `ir` into opcode/Ra/Rb/Rc and produces the one-hot register selects and `illegal`.

## Test plan
- SUB R0,R4,R5 (`ir` opcode 00010, Ra=0, Rb=4, Rc=5):
  - T3 `reg_out`=0x0010.
  - T4 `reg_out`=0x0020, `alu_op`=00010.
  - T5 `reg_in`=0x0001.
  - `done` 7 cycles after `start`.
- MUL R2,R3 (opcode 01001):
  - T5 `lo_in`, T6 `hi_in`/`z_high_out`.
  - `reg_in` never asserted; `done` after 8 cycles.
- NOT R1,R6 (opcode 01100): T3 `reg_out`=0x0040, T4 `reg_out`=0, T5 `reg_in`=0x0002.
- Illegal cases:
  - Opcode 11111: DONE at cycle 5 with `illegal`=1; no strobes in T3–T5.
  - With `NUM_REGS`=8, Rc=9 gives the same result.
- Reset and `start` handling:
  - `clr` low during T4: all outputs 0 asynchronously, IDLE after release.
  - `start` during `busy` produces no second sequence.
- With `SEQ_STEP_EN`: `step` pulsed every 3rd cycle; each state holds 3 cycles and `done` stays high until `step`.
